// File: rtl/bus_cmd_master_pkg.sv
// ---------------------------------------------------------------------------
// bus_cmd_pkg
// Shared definitions for the byte-stream-to-bus command master:
//   state_e        - FSM states of bus_cmd_master
//   WRITE_BIT      - command byte bit selecting write (1) or read (0)
//   WSTRB_MSB/LSB  - command byte field carrying the write byte enables
//   ACK_BYTE_DEF   - default response byte for a successful write
//   ERR_BYTE_DEF   - default response byte for a rejected/timed-out command
// ---------------------------------------------------------------------------
package bus_cmd_pkg;

   typedef enum logic [2:0] {
      ST_CMD  = 3'd0,
      ST_ADDR = 3'd1,
      ST_DATA = 3'd2,
      ST_BUS  = 3'd3,
      ST_GAP  = 3'd4,
      ST_RESP = 3'd5
   } state_e;

   localparam int WRITE_BIT = 7;
   localparam int WSTRB_MSB = 3;
   localparam int WSTRB_LSB = 0;

   localparam logic [7:0] ACK_BYTE_DEF = 8'hA5;
   localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;

endpackage

// File: rtl/bus_cmd_master_if.sv
// ---------------------------------------------------------------------------
// bus_cmd_master_if
// Native memory bus between an initiator and a peripheral.
//   mem_valid  initiator -> target  request pending
//   mem_ready  target -> initiator  request completes this cycle
//   mem_wstrb  initiator -> target  byte enables, 0 = read
//   mem_addr   initiator -> target  byte address
//   mem_wdata  initiator -> target  write data
//   mem_rdata  target -> initiator  read data, valid with mem_ready
// Modports: master (initiator side), slave (peripheral side).
// ---------------------------------------------------------------------------
interface bus_cmd_master_if;

   logic        mem_valid;
   logic        mem_ready;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_wstrb, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_wstrb, mem_addr, mem_wdata,
      output mem_ready, mem_rdata
   );

endinterface

// File: rtl/bus_cmd_master.sv
// ---------------------------------------------------------------------------
// bus_cmd_master
// Debug/host access path: consumes a byte command stream, performs one 32-bit
// bus read or write, and returns a byte response stream.
//   Read frame : cmd(bit7=0) + 4 address bytes        -> 4 rdata bytes, LSB first
//   Write frame: cmd(bit7=1, [3:0]=wstrb) + 4 addr + 4 data bytes -> ACK_BYTE
//   Write with wstrb 0 performs no bus access and answers ERR_BYTE.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   rx_valid/rx_ready/rx_data   command byte stream in
//   tx_valid/tx_ready/tx_data   response byte stream out
//   mem                    bus_cmd_master_if.master, native memory bus
//   busy                   high whenever the FSM is not waiting for a command
// Optional feature: define BUS_CMD_TIMEOUT_EN to abort a bus access that sees
// no mem_ready within TIMEOUT cycles; the response is then ERR_BYTE.
// ---------------------------------------------------------------------------
module bus_cmd_master
   import bus_cmd_pkg::*;
#(
   parameter int         TIMEOUT  = 255,
   parameter logic [7:0] ACK_BYTE = ACK_BYTE_DEF,
   parameter logic [7:0] ERR_BYTE = ERR_BYTE_DEF
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      rx_valid,
   output logic                      rx_ready,
   input  logic [7:0]                rx_data,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic [7:0]                tx_data,
   bus_cmd_master_if.master          mem,
   output logic                      busy
);

   state_e      state_q,     state_d;
   logic [1:0]  cnt_q,       cnt_d;
   logic        wr_q,        wr_d;
   logic        err_q,       err_d;
   logic [3:0]  wstrb_q,     wstrb_d;
   logic [31:0] addr_q,      addr_d;
   logic [31:0] wdata_q,     wdata_d;
   logic [31:0] rdata_q,     rdata_d;
   logic        mem_valid_q, mem_valid_d;
   logic        tx_valid_q,  tx_valid_d;
   logic [7:0]  tx_data_q,   tx_data_d;
   logic [1:0]  tx_cnt_q,    tx_cnt_d;
   logic        busy_q,      busy_d;
   logic        rx_accept;

`ifdef BUS_CMD_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic [TO_W-1:0] to_cnt_inc;
   assign to_cnt_inc = to_cnt_q + TO_W'(1);
`else
   logic timeout_unused;
   assign timeout_unused = |TIMEOUT;
`endif

   assign rx_ready  = resetn && (state_q inside {ST_CMD, ST_ADDR, ST_DATA});
   assign rx_accept = rx_valid && rx_ready;

   assign mem.mem_valid = mem_valid_q;
   assign mem.mem_wstrb = wstrb_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign tx_valid      = tx_valid_q;
   assign tx_data       = tx_data_q;
   assign busy          = busy_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_d        = wr_q;
      err_d       = err_q;
      wstrb_d     = wstrb_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      mem_valid_d = mem_valid_q;
      tx_valid_d  = tx_valid_q;
      tx_data_d   = tx_data_q;
      tx_cnt_d    = tx_cnt_q;
`ifdef BUS_CMD_TIMEOUT_EN
      // Held at zero outside BUS so it starts from zero on every entry.
      to_cnt_d    = '0;
`endif

      case (state_q)
         ST_CMD: begin
            if (rx_accept) begin
               wr_d    = rx_data[WRITE_BIT];
               wstrb_d = rx_data[WRITE_BIT] ? rx_data[WSTRB_MSB:WSTRB_LSB] : 4'h0;
               err_d   = 1'b0;
               cnt_d   = 2'd0;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (rx_accept) begin
               // Little-endian: bytes enter at the top and shift down.
               addr_d = {rx_data, addr_q[31:8]};
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  if (wr_q) begin
                     state_d = ST_DATA;
                  end else begin
                     state_d     = ST_BUS;
                     mem_valid_d = 1'b1;
                  end
               end
            end
         end
         ST_DATA: begin
            if (rx_accept) begin
               wdata_d = {rx_data, wdata_q[31:8]};
               cnt_d   = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  if (wstrb_q == 4'h0) begin
                     // Empty write: frame is consumed but never reaches the bus.
                     err_d   = 1'b1;
                     state_d = ST_GAP;
                  end else begin
                     state_d     = ST_BUS;
                     mem_valid_d = 1'b1;
                  end
               end
            end
         end
         ST_BUS: begin
`ifdef BUS_CMD_TIMEOUT_EN
            to_cnt_d = to_cnt_inc;
`endif
            if (mem_valid_q && mem.mem_ready) begin
               rdata_d     = mem.mem_rdata;
               mem_valid_d = 1'b0;
               state_d     = ST_GAP;
            end
`ifdef BUS_CMD_TIMEOUT_EN
            // Completion above has priority over an expiry in the same cycle.
            else if (to_cnt_inc == TO_W'(TIMEOUT)) begin
               mem_valid_d = 1'b0;
               err_d       = 1'b1;
               state_d     = ST_GAP;
            end
`endif
         end
         ST_GAP: begin
            // mem_valid is low here, so a lingering mem_ready is never sampled.
            state_d    = ST_RESP;
            tx_valid_d = 1'b1;
            tx_cnt_d   = 2'd0;
            if (err_q) begin
               tx_data_d = ERR_BYTE;
            end else if (wr_q) begin
               tx_data_d = ACK_BYTE;
            end else begin
               tx_data_d = rdata_q[7:0];
               rdata_d   = {8'h00, rdata_q[31:8]};
            end
         end
         ST_RESP: begin
            if (tx_ready) begin
               if (err_q || wr_q || tx_cnt_q == 2'd3) begin
                  tx_valid_d = 1'b0;
                  state_d    = ST_CMD;
               end else begin
                  tx_cnt_d  = tx_cnt_q + 2'd1;
                  tx_data_d = rdata_q[7:0];
                  rdata_d   = {8'h00, rdata_q[31:8]};
               end
            end
         end
         default: begin
            state_d = ST_CMD;
         end
      endcase

      busy_d = (state_d != ST_CMD);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= ST_CMD;
         cnt_q       <= 2'd0;
         wr_q        <= 1'b0;
         err_q       <= 1'b0;
         wstrb_q     <= 4'h0;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         rdata_q     <= 32'h0;
         mem_valid_q <= 1'b0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= 8'h00;
         tx_cnt_q    <= 2'd0;
         busy_q      <= 1'b0;
`ifdef BUS_CMD_TIMEOUT_EN
         to_cnt_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_q        <= wr_d;
         err_q       <= err_d;
         wstrb_q     <= wstrb_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         mem_valid_q <= mem_valid_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
         tx_cnt_q    <= tx_cnt_d;
         busy_q      <= busy_d;
`ifdef BUS_CMD_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_bus_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_bus_cmd_master
// Directed bench for bus_cmd_master. A registered responder (ready <= valid)
// stands in for a peripheral; a monitor records each bus transaction.
// Build with BUS_CMD_TIMEOUT_EN to include the timeout scenario (TIMEOUT=16).
// ---------------------------------------------------------------------------
module tb_bus_cmd_master;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_ready;
   logic       tx_valid;
   logic       tx_ready = 1'b0;
   logic [7:0] tx_data;
   logic       busy;

   bus_cmd_master_if mem_if ();

   bus_cmd_master #(.TIMEOUT(TO)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .rx_data  (rx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_data  (tx_data),
      .mem      (mem_if),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Responder: registered ready that simply follows valid.
   logic        resp_en = 1'b0;
   logic [31:0] rdata_val = 32'h0;
   always @(posedge clk) mem_if.mem_ready <= resp_en ? mem_if.mem_valid : 1'b0;
   assign mem_if.mem_rdata = rdata_val;

   // Bus monitor, sampled on the falling edge.
   int          txn_cnt = 0;
   int          valid_len = 0;
   int          last_len = 0;
   int          low_run = 1000;
   int          low_before = 1000;
   int          stab_err = 0;
   logic        prev_v = 1'b0;
   logic [31:0] rec_addr = 32'h0;
   logic [31:0] rec_wdata = 32'h0;
   logic [3:0]  rec_wstrb = 4'h0;

   always @(negedge clk) begin
      if (mem_if.mem_valid === 1'b1) begin
         if (!prev_v) begin
            txn_cnt++;
            low_before = low_run;
            valid_len  = 0;
            rec_addr   = mem_if.mem_addr;
            rec_wdata  = mem_if.mem_wdata;
            rec_wstrb  = mem_if.mem_wstrb;
            $display("bus txn %0d: addr=%08h wdata=%08h wstrb=%h", txn_cnt,
                     mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wstrb);
         end else if (mem_if.mem_addr !== rec_addr || mem_if.mem_wdata !== rec_wdata ||
                      mem_if.mem_wstrb !== rec_wstrb) begin
            stab_err++;
         end
         valid_len++;
         prev_v = 1'b1;
      end else begin
         if (prev_v) begin
            last_len = valid_len;
            low_run  = 1;
         end else begin
            low_run++;
         end
         prev_v = 1'b0;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- stimulus tasks ----------------
   task automatic send_byte(input logic [7:0] b, output bit ok);
      int t;
      t  = 0;
      ok = 1'b0;
      rx_valid = 1'b1;
      rx_data  = b;
      while (t < 100) begin
         @(negedge clk);
         if (rx_ready) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
            break;
         end
         t++;
      end
      rx_valid = 1'b0;
   endtask

   task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] addr,
                           input logic [31:0] wdata, output bit ok);
      bit b_ok;
      ok = 1'b1;
      send_byte(cmd, b_ok);
      ok &= b_ok;
      for (int i = 0; i < 4; i++) begin
         send_byte(addr[8*i +: 8], b_ok);
         ok &= b_ok;
      end
      if (cmd[7]) begin
         for (int i = 0; i < 4; i++) begin
            send_byte(wdata[8*i +: 8], b_ok);
            ok &= b_ok;
         end
      end
      $display("sent cmd=%02h addr=%08h wdata=%08h", cmd, addr, wdata);
   endtask

   // Waits for a response byte, stalls it for 'stall' cycles, then takes it.
   task automatic get_byte(input int stall, output logic [7:0] b, output bit ok,
                           output int stall_bad);
      int          t;
      logic [7:0]  first;
      t         = 0;
      stall_bad = 0;
      ok        = 1'b0;
      b         = 8'h00;
      tx_ready  = 1'b0;
      while (tx_valid !== 1'b1 && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (tx_valid !== 1'b1) return;
      first = tx_data;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         if (tx_valid !== 1'b1 || tx_data !== first) stall_bad++;
      end
      tx_ready = 1'b1;
      b        = tx_data;
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
      ok       = 1'b1;
      $display("rx response byte %02h", b);
   endtask

   task automatic run_read(input logic [31:0] addr, input int stall,
                           output logic [31:0] word, output bit ok, output int stall_bad);
      bit         f_ok, b_ok;
      logic [7:0] b;
      int         sb;
      stall_bad = 0;
      word      = 32'h0;
      send_cmd(8'h00, addr, 32'h0, f_ok);
      ok = f_ok;
      for (int i = 0; i < 4; i++) begin
         get_byte(stall, b, b_ok, sb);
         ok &= b_ok;
         stall_bad += sb;
         word[8*i +: 8] = b;
      end
   endtask

   // ---------------- scenario tasks ----------------
   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (mem_if.mem_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mem_valid: got %b want 0", mem_if.mem_valid); end
      n_cmp++; if (mem_if.mem_wstrb !== 4'h0) begin n_bad++; $display("FAIL reset_wstrb: got %h want 0", mem_if.mem_wstrb); end
      n_cmp++; if (mem_if.mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %08h want 0", mem_if.mem_addr); end
      n_cmp++; if (mem_if.mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %08h want 0", mem_if.mem_wdata); end
      n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
      n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %02h want 00", tx_data); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
      resetn = 1'b1;
      #1;
      n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL idle_rx_ready: got %b want 1", rx_ready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_write();
      bit         ok;
      logic [7:0] b;
      int         sb, base;
      resp_en = 1'b1;
      base    = txn_cnt;
      send_cmd(8'h8F, 32'h0200_0004, 32'h1234_5678, ok);
      n_cmp++; if (!ok || mem_if.mem_valid !== 1'b1) begin n_bad++; $display("FAIL write_latency: frame_ok=%0d mem_valid=%b want 1", ok, mem_if.mem_valid); end
      get_byte(0, b, ok, sb);
      n_cmp++; if (!ok || b !== 8'hA5) begin n_bad++; $display("FAIL write_ack: got %02h (ok=%0d) want a5", b, ok); end
      n_cmp++; if (txn_cnt !== base + 1) begin n_bad++; $display("FAIL write_txn_count: got %0d want %0d", txn_cnt, base + 1); end
      n_cmp++; if (rec_addr !== 32'h0200_0004) begin n_bad++; $display("FAIL write_addr: got %08h want 02000004", rec_addr); end
      n_cmp++; if (rec_wdata !== 32'h1234_5678) begin n_bad++; $display("FAIL write_wdata: got %08h want 12345678", rec_wdata); end
      n_cmp++; if (rec_wstrb !== 4'hF) begin n_bad++; $display("FAIL write_wstrb: got %h want f", rec_wstrb); end
      n_cmp++; if (last_len !== 2) begin n_bad++; $display("FAIL write_valid_len: got %0d want 2", last_len); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL write_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_read();
      bit          ok, b_ok;
      logic [7:0]  b;
      logic [31:0] exp_word;
      int          sb;
      resp_en   = 1'b1;
      rdata_val = 32'hDEAD_BEEF;
      exp_word  = 32'hDEAD_BEEF;
      send_cmd(8'h00, 32'h0200_0008, 32'h0, ok);
      n_cmp++; if (!ok || mem_if.mem_valid !== 1'b1) begin n_bad++; $display("FAIL read_latency: frame_ok=%0d mem_valid=%b want 1", ok, mem_if.mem_valid); end
      for (int i = 0; i < 4; i++) begin
         get_byte(0, b, b_ok, sb);
         n_cmp++; if (!b_ok || b !== exp_word[8*i +: 8]) begin n_bad++; $display("FAIL read_byte%0d: got %02h want %02h", i, b, exp_word[8*i +: 8]); end
      end
      n_cmp++; if (rec_wstrb !== 4'h0) begin n_bad++; $display("FAIL read_wstrb: got %h want 0", rec_wstrb); end
      n_cmp++; if (rec_addr !== 32'h0200_0008) begin n_bad++; $display("FAIL read_addr: got %08h want 02000008", rec_addr); end
   endtask

   task automatic test_back_to_back();
      bit          ok;
      logic [31:0] word;
      int          sb;
      resp_en   = 1'b1;
      rdata_val = 32'h1122_3344;
      run_read(32'h0000_0010, 5, word, ok, sb);
      n_cmp++; if (!ok || word !== 32'h1122_3344) begin n_bad++; $display("FAIL b2b_first_data: got %08h want 11223344", word); end
      n_cmp++; if (sb !== 0) begin n_bad++; $display("FAIL b2b_first_stall: %0d unstable cycles want 0", sb); end
      n_cmp++; if (last_len !== 2) begin n_bad++; $display("FAIL b2b_first_len: got %0d want 2", last_len); end
      rdata_val = 32'hCAFE_F00D;
      run_read(32'h0000_0020, 5, word, ok, sb);
      n_cmp++; if (!ok || word !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL b2b_second_data: got %08h want cafef00d", word); end
      n_cmp++; if (sb !== 0) begin n_bad++; $display("FAIL b2b_second_stall: %0d unstable cycles want 0", sb); end
      n_cmp++; if (low_before < 1) begin n_bad++; $display("FAIL b2b_gap: got %0d low cycles want >=1", low_before); end
      n_cmp++; if (last_len !== 2) begin n_bad++; $display("FAIL b2b_second_len: got %0d want 2", last_len); end
      n_cmp++; if (rec_addr !== 32'h0000_0020) begin n_bad++; $display("FAIL b2b_second_addr: got %08h want 00000020", rec_addr); end
   endtask

   task automatic test_wstrb_zero();
      bit         ok;
      logic [7:0] b;
      int         sb, base;
      resp_en = 1'b1;
      base    = txn_cnt;
      send_cmd(8'h80, 32'h0000_0040, 32'hAABB_CCDD, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL wstrb0_frame: frame_ok=%0d want 1", ok); end
      get_byte(0, b, ok, sb);
      n_cmp++; if (!ok || b !== 8'hEE) begin n_bad++; $display("FAIL wstrb0_resp: got %02h want ee", b); end
      n_cmp++; if (txn_cnt !== base) begin n_bad++; $display("FAIL wstrb0_no_bus: got %0d txns want %0d", txn_cnt, base); end
   endtask

`ifdef BUS_CMD_TIMEOUT_EN
   task automatic test_timeout();
      bit          ok;
      logic [7:0]  b;
      logic [31:0] word;
      int          sb;
      resp_en = 1'b0;
      send_cmd(8'h00, 32'h0000_0030, 32'h0, ok);
      get_byte(0, b, ok, sb);
      n_cmp++; if (!ok || b !== 8'hEE) begin n_bad++; $display("FAIL timeout_resp: got %02h want ee", b); end
      n_cmp++; if (last_len !== TO) begin n_bad++; $display("FAIL timeout_len: got %0d want %0d", last_len, TO); end
      resp_en   = 1'b1;
      rdata_val = 32'h0BAD_F00D;
      run_read(32'h0000_0034, 0, word, ok, sb);
      n_cmp++; if (!ok || word !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL timeout_recover: got %08h want 0badf00d", word); end
   endtask
`endif

   task automatic test_reset_mid();
      bit          ok;
      logic [31:0] word;
      int          sb, tx_seen;
      resp_en = 1'b0;
      send_cmd(8'h00, 32'h0000_0050, 32'h0, ok);
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (mem_if.mem_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_pending: mem_valid=%b want 1", mem_if.mem_valid); end
      resetn = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++; if (mem_if.mem_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_drop: mem_valid=%b want 0", mem_if.mem_valid); end
      resetn  = 1'b1;
      tx_seen = 0;
      tx_ready = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (tx_valid !== 1'b0) tx_seen++;
      end
      tx_ready = 1'b0;
      n_cmp++; if (tx_seen !== 0) begin n_bad++; $display("FAIL rstmid_no_tx: got %0d tx cycles want 0", tx_seen); end
      resp_en   = 1'b1;
      rdata_val = 32'h55AA_1234;
      run_read(32'h0000_0054, 0, word, ok, sb);
      n_cmp++; if (!ok || word !== 32'h55AA_1234) begin n_bad++; $display("FAIL rstmid_fresh_read: got %08h want 55aa1234", word); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_wstrb_zero();
`ifdef BUS_CMD_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
